inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, minimum 2.
REQ-002 Parameter AFULL_LVL, default DEPTH-2, occupancy at or above which almost_full is asserted.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 flush  in  1  discard all entries (redirect from the hazard controller).
REQ-006 enq_valid  in  1  fetch offers an entry (i-cache hit).
REQ-007 enq_pc  in  32  PC of the offered instruction.
REQ-008 enq_inst  in  32  instruction word.
REQ-009 full  out  1  occupancy == DEPTH; consumed as the fetch-stall term.
REQ-010 almost_full  out  1  occupancy >= AFULL_LVL.
REQ-011 deq_ready  in  1  decode accepts the head entry (decode not stalled).
REQ-012 deq_valid  out  1  head entry valid.
REQ-013 deq_pc  out  32  head PC.
REQ-014 deq_inst  out  32  head instruction word.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Storage SHALL be a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH with no special case.
REQ-017 An enqueue SHALL occur when enq_valid & !full & !flush; the entry is written at wr_ptr and wr_ptr increments.
REQ-018 When full, enq_valid SHALL be ignored even if a dequeue occurs in the same cycle; there is no full-bypass.
REQ-019 A dequeue SHALL occur when deq_valid & deq_ready; rd_ptr increments.
REQ-020 deq_valid SHALL equal (count != 0) & !flush; deq_pc and deq_inst SHALL be driven combinationally from entry[rd_ptr].
REQ-021 deq_pc and deq_inst SHALL be 0 whenever deq_valid is 0.
REQ-022 Latency: an entry enqueued at edge N SHALL appear on deq_* during the cycle after edge N; there is no same-cycle enq-to-deq bypass.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-024 count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-025 full, almost_full and count SHALL be registered-state derived, with no combinational path from enq_valid or deq_ready.
REQ-026 flush SHALL take priority over enqueue and dequeue: at the next edge wr_ptr, rd_ptr and count become 0, and any entry offered that cycle is dropped.
REQ-027 Stored data SHALL NOT be cleared on flush; only the pointers and count are reset.
REQ-028 A deq_ready with an empty queue SHALL have no effect.

Reset
REQ-029 While rst is high, wr_ptr, rd_ptr and count SHALL be 0 immediately (asynchronous); full=0, almost_full=0, deq_valid=0, deq_pc=0, deq_inst=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first enqueue after deassertion SHALL write slot 0.
REQ-031 Entry storage SHALL NOT require reset.

Structure
REQ-032 Typedef inst_q_entry {pc[31:0], inst[31:0]} and the constant INST_Q_DEPTH SHALL reside in the shared mips_core package.
REQ-033 The entry array SHALL be one sub-module, inst_q_storage: 1 write port, 1 asynchronous read port, DEPTH x inst_q_entry.
REQ-034 The pointer, count and flag logic SHALL reside in inst_queue itself.

Verification
REQ-035 After reset, enqueue PCs 0x100,0x104,0x108 with deq_ready=0 -> count=3, deq_pc=0x100; then deq_ready=1 for 3 cycles -> deq_pc 0x100,0x104,0x108, then deq_valid=0.
REQ-036 With DEPTH=8, enqueue 8 entries with no dequeue -> full=1 and almost_full=1 (from count=6); a 9th enq_valid is dropped and count stays 8.
REQ-037 Full queue with enq_valid=1 and deq_ready=1 together -> dequeue only, count=7, full=0; next cycle the enqueue is accepted, count=8.
REQ-038 count=4 with flush=1, enq_valid=1 and deq_ready=1 in the same cycle -> deq_valid=0 that cycle, count=0 next cycle, enqueued PC absent.
REQ-039 Stream 20 entries with random deq_ready -> in-order output across pointer wrap, no loss or duplication, scoreboard matches.
REQ-040 Assert rst asynchronously mid-stream at count=5 -> outputs are zero before the next edge; after release, enqueue 0x200 -> deq_pc=0x200.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: the instruction-queue entry format and its default depth.
package mips_core_pkg;

   localparam int INST_Q_DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } inst_q_entry;

endpackage

// File: rtl/inst_q_storage.sv
// DEPTH x inst_q_entry array: one synchronous write port and one asynchronous read port.
module inst_q_storage
   import mips_core_pkg::*;
#(
   parameter int DEPTH = INST_Q_DEPTH
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  inst_q_entry              i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output inst_q_entry              o_rdata
);

   // Contents are never reset; occupancy alone decides which slots are meaningful.
   inst_q_entry r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer with flush, occupancy count and full flags.
module inst_queue
   import mips_core_pkg::*;
#(
   parameter int DEPTH     = INST_Q_DEPTH,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   enq_valid,
   input  logic [31:0]            enq_pc,
   input  logic [31:0]            enq_inst,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   deq_ready,
   output logic                   deq_valid,
   output logic [31:0]            deq_pc,
   output logic [31:0]            deq_inst,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_enq;
   logic          w_deq;
   inst_q_entry   w_wdata;
   inst_q_entry   w_rdata;

   // Flags depend only on registered occupancy so fetch stall has no path from decode.
   assign full        = (r_count == DEPTH_C);
   assign almost_full = (r_count >= AFULL_C);
   assign count       = r_count;

   assign deq_valid = (r_count != '0) & ~flush;
   assign deq_pc    = deq_valid ? w_rdata.pc   : '0;
   assign deq_inst  = deq_valid ? w_rdata.inst : '0;

   assign w_enq   = enq_valid & ~full & ~flush;
   assign w_deq   = deq_valid & deq_ready;
   assign w_wdata = '{pc: enq_pc, inst: enq_inst};

   inst_q_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk     (clk),
      .i_we    (w_enq),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Pointers wrap by natural overflow since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
